// File: rtl/hermes_inbuf_if.sv
// Link bundle of one Hermes input buffer: upstream flit port, routing handshake
// with switch control, and the downstream flit port toward the crossbar.
interface hermes_inbuf_if #(
  parameter int FLIT_SIZE = 32
);
  logic                 rx_i;
  logic [FLIT_SIZE-1:0] data_i;
  logic                 credit_o;
  logic                 req_o;
  logic                 ack_i;
  logic                 sending_o;
  logic                 tx_o;
  logic [FLIT_SIZE-1:0] data_o;
  logic                 credit_i;

  modport slave (
    input  rx_i, data_i, ack_i, credit_i,
    output credit_o, req_o, sending_o, tx_o, data_o
  );

  modport master (
    output rx_i, data_i, ack_i, credit_i,
    input  credit_o, req_o, sending_o, tx_o, data_o
  );
endinterface

// File: rtl/hermes_inbuf.sv
// Hermes router input buffer: circular flit FIFO plus packet forwarding FSM.
// Optional packet counter output enabled by HERMES_INBUF_PKT_CNT_EN.
module hermes_inbuf #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
`ifdef HERMES_INBUF_PKT_CNT_EN
  output logic [15:0]   pkt_cnt_o,
`endif
  hermes_inbuf_if.slave bus
);
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(BUFFER_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HEADER, S_SIZE, S_PAYLOAD} state_e;

  state_e               state_q, state_d;
  logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FLIT_SIZE-1:0] flit_cnt_q, flit_cnt_d;
  logic                 full, empty, push, pop, sending, tx, pkt_done;
  logic [FLIT_SIZE-1:0] head;

  assign full  = (cnt_q == DEPTH);
  assign empty = (cnt_q == '0);
  assign push  = bus.rx_i && !full;
  assign pop   = tx && bus.credit_i;
  assign head  = mem_q[rd_ptr_q];

  // Head is only consumed by pops, and pops need sending, so it is frozen in S_REQ.
  assign sending = (state_q == S_HEADER) || (state_q == S_SIZE) || (state_q == S_PAYLOAD);
  assign tx      = sending && !empty;

  assign bus.credit_o  = !full;
  assign bus.data_o    = head;
  assign bus.req_o     = (state_q == S_REQ);
  assign bus.sending_o = sending;
  assign bus.tx_o      = tx;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_i;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    pkt_done   = 1'b0;
    case (state_q)
      S_IDLE:   if (!empty) state_d = S_REQ;
      S_REQ:    if (bus.ack_i) state_d = S_HEADER;
      S_HEADER: if (pop) state_d = S_SIZE;
      S_SIZE: begin
        if (pop) begin
          flit_cnt_d = head;
          if (head == '0) begin
            state_d  = S_IDLE;
            pkt_done = 1'b1;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (pop) begin
          flit_cnt_d = flit_cnt_q - 1'b1;
          if (flit_cnt_q == FLIT_SIZE'(1)) begin
            state_d  = S_IDLE;
            pkt_done = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      flit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flit_cnt_q <= flit_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

`ifdef HERMES_INBUF_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                pkt_cnt_q <= '0;
    else if (pkt_done && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 1'b1;
  end

  assign pkt_cnt_o = pkt_cnt_q;
`else
  logic unused_pkt_done;
  assign unused_pkt_done = pkt_done;
`endif

  // Upstream must honour credit_o; a flit offered while full is silently lost.
  rx_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(bus.rx_i && full))
    else $warning("hermes_inbuf: rx_i while buffer full, flit dropped");
endmodule
